// File: rtl/traffic_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : traffic_monitor_if                                     |
// | Description : Lamp-code bus between an intersection controller and   |
// |               the traffic_monitor safety checker.                    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface traffic_monitor_if;
   logic [4:0] p1;
   logic [4:0] p2;
   logic [4:0] p3;
   logic [4:0] p4;
   logic [3:0] pl;
   logic       clr_fault;
   logic [1:0] lamp1;
   logic [1:0] lamp2;
   logic [1:0] lamp3;
   logic [1:0] lamp4;
   logic       ped_walk;
   logic       fault;
   logic [2:0] fault_code;
   logic [2:0] fault_src;
   logic       force_red;
   logic [7:0] round_cnt;

   // Controller / environment side
   modport master (
      output p1, p2, p3, p4, pl, clr_fault,
      input  lamp1, lamp2, lamp3, lamp4, ped_walk,
      input  fault, fault_code, fault_src, force_red, round_cnt
   );

   // Monitor side
   modport slave (
      input  p1, p2, p3, p4, pl, clr_fault,
      output lamp1, lamp2, lamp3, lamp4, ped_walk,
      output fault, fault_code, fault_src, force_red, round_cnt
   );
endinterface
`default_nettype wire

// File: rtl/traffic_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : traffic_monitor                                        |
// | Description : Samples the intersection lamp codes, decodes them and  |
// |               latches the first safety fault (invalid code, conflict,|
// |               illegal sequence, short yellow, stuck inputs).         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module traffic_monitor #(
   parameter int MIN_YELLOW = 2,
   parameter int WDOG_LIMIT = 64
) (
   input  logic             clk,
   input  logic             reset,
   traffic_monitor_if.slave bus
);

   // Enum values double as the lamp output encoding
   typedef enum logic [1:0] {
      ROAD_RED    = 2'b00,
      ROAD_GREEN  = 2'b01,
      ROAD_YELLOW = 2'b10,
      ROAD_BAD    = 2'b11
   } road_e;

   localparam logic [4:0]  c_ROAD_GREEN  = 5'b10011;
   localparam logic [4:0]  c_ROAD_YELLOW = 5'b01000;
   localparam logic [4:0]  c_ROAD_RED    = 5'b00100;
   localparam logic [3:0]  c_PED_WALK    = 4'b0000;
   localparam logic [3:0]  c_PED_STOP    = 4'b1111;
   // Sample word layout: {pl, p4, p3, p2, p1}
   localparam logic [23:0] c_IDLE_PATTERN = {c_PED_STOP, {4{c_ROAD_RED}}};
   localparam int          WD_W           = $clog2(WDOG_LIMIT + 1);
   localparam logic [WD_W-1:0] c_WD_MAX   = WD_W'(WDOG_LIMIT);
   localparam logic [4:0]  c_MIN_YELLOW   = 5'(MIN_YELLOW);
   localparam logic [3:0]  c_DWELL_MAX    = 4'd15;

   function automatic road_e decode_road(input logic [4:0] code);
      case (code)
         c_ROAD_GREEN:  decode_road = ROAD_GREEN;
         c_ROAD_YELLOW: decode_road = ROAD_YELLOW;
         c_ROAD_RED:    decode_road = ROAD_RED;
         default:       decode_road = ROAD_BAD;
      endcase
   endfunction

   // Index of the lowest set bit (bit 0 = pedestrian, 1..4 = roads)
   function automatic logic [2:0] first_set(input logic [4:0] v);
      first_set = 3'd0;
      for (int k = 4; k >= 0; k--) begin
         if (v[k]) first_set = 3'(k);
      end
   endfunction

   logic [23:0]     samp_q, prev_q;
   road_e           st_q [4];
   road_e           st_d [4];
   logic [3:0]      dwell_q [4];
   logic [3:0]      dwell_d [4];
   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            fault_q, fault_d;
   logic [2:0]      code_q, code_d;
   logic [2:0]      src_q, src_d;
   logic [7:0]      round_q, round_d;

   road_e           w_dec [4];
   logic            w_walk;
   logic            w_same;
   logic [4:0]      w_inv, w_nonred, w_illegal, w_short;
   logic [2:0]      w_nonred_cnt;
   logic            w_new_fault;
   logic [2:0]      w_new_code, w_new_src;

   assign w_walk = (samp_q[23:20] == c_PED_WALK);
   assign w_same = (samp_q == prev_q);

   // Decode the sampled road codes
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_dec[i] = decode_road(samp_q[5*i +: 5]);
      end
   end

   // Per-source fault conditions from sample stage versus tracked history
   always_comb begin
      w_inv        = 5'd0;
      w_nonred     = 5'd0;
      w_illegal    = 5'd0;
      w_short      = 5'd0;
      w_nonred_cnt = 3'd0;
      w_inv[0]     = !((samp_q[23:20] == c_PED_WALK) || (samp_q[23:20] == c_PED_STOP));
      for (int i = 0; i < 4; i++) begin
         w_inv[i+1]    = (w_dec[i] == ROAD_BAD);
         w_nonred[i+1] = (w_dec[i] == ROAD_GREEN) || (w_dec[i] == ROAD_YELLOW);
         w_nonred_cnt  = w_nonred_cnt + {2'b00, w_nonred[i+1]};
         // An invalid code is reported as such and never as a transition
         if (w_dec[i] != ROAD_BAD) begin
            case (st_q[i])
               ROAD_RED:    w_illegal[i+1] = (w_dec[i] == ROAD_YELLOW);
               ROAD_GREEN:  w_illegal[i+1] = (w_dec[i] == ROAD_RED);
               ROAD_YELLOW: begin
                  w_illegal[i+1] = (w_dec[i] == ROAD_GREEN);
                  w_short[i+1]   = (w_dec[i] == ROAD_RED) &&
                                   ({1'b0, dwell_q[i]} < c_MIN_YELLOW);
               end
               default:     w_illegal[i+1] = 1'b0;
            endcase
         end
      end
   end

   // Pick the winning fault: lowest code, then lowest source
   always_comb begin
      w_new_fault = 1'b0;
      w_new_code  = 3'd0;
      w_new_src   = 3'd0;
      if (|w_inv) begin
         w_new_fault = 1'b1;
         w_new_code  = 3'd1;
         w_new_src   = first_set(w_inv);
      end else if (w_nonred_cnt > 3'd1) begin
         w_new_fault = 1'b1;
         w_new_code  = 3'd2;
         w_new_src   = first_set(w_nonred);
      end else if (w_walk && (w_nonred_cnt != 3'd0)) begin
         w_new_fault = 1'b1;
         w_new_code  = 3'd3;
      end else if (|w_illegal) begin
         w_new_fault = 1'b1;
         w_new_code  = 3'd4;
         w_new_src   = first_set(w_illegal);
      end else if (|w_short) begin
         w_new_fault = 1'b1;
         w_new_code  = 3'd5;
         w_new_src   = first_set(w_short);
      end else if (wdog_q == c_WD_MAX) begin
         w_new_fault = 1'b1;
         w_new_code  = 3'd6;
      end
   end

   // Next state for road tracking, dwell, rotation count, watchdog and fault latch
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         st_d[i]    = st_q[i];
         dwell_d[i] = dwell_q[i];
         if (w_dec[i] != ROAD_BAD) begin
            st_d[i] = w_dec[i];
            // Dwell counts yellow sample cycles, restarting at each yellow entry
            if (w_dec[i] == ROAD_YELLOW) begin
               if (st_q[i] != ROAD_YELLOW)
                  dwell_d[i] = 4'd1;
               else if (dwell_q[i] != c_DWELL_MAX)
                  dwell_d[i] = dwell_q[i] + 4'd1;
            end
         end
      end

      round_d = round_q;
      if ((st_q[0] == ROAD_RED) && (w_dec[0] == ROAD_GREEN))
         round_d = round_q + 8'd1;

      wdog_d = '0;
      if (!bus.clr_fault && w_same)
         wdog_d = (wdog_q == c_WD_MAX) ? wdog_q : wdog_q + 1'b1;

      fault_d = fault_q;
      code_d  = code_q;
      src_d   = src_q;
      if (bus.clr_fault) begin
         fault_d = 1'b0;
         code_d  = 3'd0;
         src_d   = 3'd0;
      end
      // A fault arriving with the clear wins over the clear
      if (w_new_fault && (!fault_q || bus.clr_fault)) begin
         fault_d = 1'b1;
         code_d  = w_new_code;
         src_d   = w_new_src;
      end
   end

   // State registers; reset loads the idle all-red / STOP pattern
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         samp_q  <= c_IDLE_PATTERN;
         prev_q  <= c_IDLE_PATTERN;
         for (int i = 0; i < 4; i++) begin
            st_q[i]    <= ROAD_RED;
            dwell_q[i] <= 4'd0;
         end
         wdog_q  <= '0;
         fault_q <= 1'b0;
         code_q  <= 3'd0;
         src_q   <= 3'd0;
         round_q <= 8'd0;
      end else begin
         samp_q  <= {bus.pl, bus.p4, bus.p3, bus.p2, bus.p1};
         prev_q  <= samp_q;
         for (int i = 0; i < 4; i++) begin
            st_q[i]    <= st_d[i];
            dwell_q[i] <= dwell_d[i];
         end
         wdog_q  <= wdog_d;
         fault_q <= fault_d;
         code_q  <= code_d;
         src_q   <= src_d;
         round_q <= round_d;
      end
   end

   assign bus.lamp1      = w_dec[0];
   assign bus.lamp2      = w_dec[1];
   assign bus.lamp3      = w_dec[2];
   assign bus.lamp4      = w_dec[3];
   assign bus.ped_walk   = w_walk;
   assign bus.fault      = fault_q;
   assign bus.fault_code = code_q;
   assign bus.fault_src  = src_q;
   assign bus.force_red  = fault_q;
   assign bus.round_cnt  = round_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_traffic_monitor                                     |
// | Description : Directed and random stimulus for traffic_monitor,      |
// |               checked against a rule-level reference model.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_traffic_monitor;
   localparam int MIN_Y  = 2;
   localparam int WD_LIM = 64;
   localparam logic [4:0] G  = 5'b10011;
   localparam logic [4:0] Y  = 5'b01000;
   localparam logic [4:0] R  = 5'b00100;
   localparam logic [3:0] PW = 4'b0000;
   localparam logic [3:0] PS = 4'b1111;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   traffic_monitor_if bus ();

   traffic_monitor #(.MIN_YELLOW(MIN_Y), .WDOG_LIMIT(WD_LIM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: index 0..3 roads, 4 pedestrian; road state 0 red 1 green 2 yellow
   int m_samp [5];
   int m_prev [5];
   int m_state [4];
   int m_dwell [4];
   int m_wd, m_code, m_src, m_round;
   bit m_fault;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int rdec(input int c);
      if (c == 19) return 1;       // 10011
      else if (c == 8) return 2;   // 01000
      else if (c == 4) return 0;   // 00100
      else return 3;
   endfunction

   function automatic int rank(input int best, input int code, input int src);
      int k;
      k = code * 8 + src;
      return (k < best) ? k : best;
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < 4; i++) begin
         m_samp[i] = 4; m_prev[i] = 4; m_state[i] = 0; m_dwell[i] = 0;
      end
      m_samp[4] = 15; m_prev[4] = 15;
      m_wd = 0; m_code = 0; m_src = 0; m_round = 0; m_fault = 1'b0;
   endtask

   task automatic mdl_step();
      int v [4];
      int nin [5];
      int best, nonred, first_nr;
      bit same, clr;
      nin[0] = int'(bus.p1); nin[1] = int'(bus.p2); nin[2] = int'(bus.p3);
      nin[3] = int'(bus.p4); nin[4] = int'(bus.pl);
      clr  = bus.clr_fault;
      best = 99;
      for (int i = 0; i < 4; i++) v[i] = rdec(m_samp[i]);
      if (m_samp[4] != 0 && m_samp[4] != 15) best = rank(best, 1, 0);
      nonred = 0; first_nr = 0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i] == 3) best = rank(best, 1, i + 1);
         if (v[i] == 1 || v[i] == 2) begin nonred++; first_nr = i + 1; end
      end
      if (nonred > 1) best = rank(best, 2, first_nr);
      if (m_samp[4] == 0 && nonred > 0) best = rank(best, 3, 0);
      for (int i = 0; i < 4; i++) begin
         if (v[i] != 3) begin
            if (v[i] != m_state[i] && v[i] != (m_state[i] + 1) % 3) best = rank(best, 4, i + 1);
            if (m_state[i] == 2 && v[i] == 0 && m_dwell[i] < MIN_Y) best = rank(best, 5, i + 1);
         end
      end
      if (m_wd >= WD_LIM) best = rank(best, 6, 0);
      if (clr) begin m_fault = 1'b0; m_code = 0; m_src = 0; end
      if (best < 99 && !m_fault) begin
         m_fault = 1'b1; m_code = best / 8; m_src = best % 8;
      end
      if (m_state[0] == 0 && v[0] == 1) m_round = (m_round + 1) % 256;
      for (int i = 0; i < 4; i++) begin
         if (v[i] != 3) begin
            if (v[i] == 2) m_dwell[i] = (m_state[i] == 2) ? ((m_dwell[i] < 15) ? m_dwell[i] + 1 : 15) : 1;
            m_state[i] = v[i];
         end
      end
      same = 1'b1;
      for (int k = 0; k < 5; k++) if (m_samp[k] != m_prev[k]) same = 1'b0;
      if (clr || !same) m_wd = 0;
      else if (m_wd < WD_LIM) m_wd++;
      m_prev = m_samp;
      m_samp = nin;
   endtask

   function automatic logic [31:0] mdl_vec();
      logic [1:0] l [4];
      for (int i = 0; i < 4; i++) l[i] = 2'(rdec(m_samp[i]));
      return {7'd0, l[0], l[1], l[2], l[3], (m_samp[4] == 0), m_fault, 3'(m_code),
              3'(m_src), m_fault, 8'(m_round)};
   endfunction

   function automatic logic [31:0] dut_vec();
      return {7'd0, bus.lamp1, bus.lamp2, bus.lamp3, bus.lamp4, bus.ped_walk, bus.fault,
              bus.fault_code, bus.fault_src, bus.force_red, bus.round_cnt};
   endfunction

   function automatic logic [31:0] fcs();
      return 32'({bus.fault, bus.force_red, bus.fault_code, bus.fault_src});
   endfunction

   task automatic drv(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                      input logic [4:0] d, input logic [3:0] p);
      bus.p1 = a; bus.p2 = b; bus.p3 = c; bus.p4 = d; bus.pl = p;
   endtask

   task automatic step();
      @(posedge clk);
      mdl_step();
      #1;
      chk("outs", dut_vec(), mdl_vec());
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      bus.clr_fault = 1'b0;
      drv(R, R, R, R, PS);
      mdl_reset();
      repeat (2) @(negedge clk);
      chk("reset_outs", dut_vec(), 32'd0);
      reset = 1'b1;
   endtask

   function automatic logic [4:0] rnd_road();
      int r;
      r = $urandom_range(0, 9);
      if (r < 3) return R;
      else if (r < 6) return G;
      else if (r < 9) return Y;
      else return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      #400000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [4:0] rr [4];
      drv(R, R, R, R, PS);
      bus.clr_fault = 1'b0;
      mdl_reset();

      // Normal controller rotation, three rounds
      do_reset();
      for (int rnd = 0; rnd < 3; rnd++) begin
         for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) rr[k] = R;
            rr[i] = G; drv(rr[0], rr[1], rr[2], rr[3], PS); repeat (4) step();
            rr[i] = Y; drv(rr[0], rr[1], rr[2], rr[3], PS); repeat (4) step();
            rr[i] = R; drv(rr[0], rr[1], rr[2], rr[3], PS);
         end
         drv(R, R, R, R, PW); repeat (4) step();
         drv(R, R, R, R, PS); step();
      end
      step();
      chk("normal_fault", 32'(bus.fault), 32'd0);
      chk("normal_round", 32'(bus.round_cnt), 32'd3);

      // Two greens at once
      do_reset();
      drv(G, G, R, R, PS);
      step();
      chk("conflict_early", 32'(bus.fault), 32'd0);
      step();
      chk("conflict", fcs(), 32'({1'b1, 1'b1, 3'd2, 3'd1}));

      // Invalid code, then sticky behaviour, then clear
      do_reset();
      drv(R, R, 5'b11111, R, PS); step(); step();
      chk("invalid", fcs(), 32'({1'b1, 1'b1, 3'd1, 3'd3}));
      drv(G, G, 5'b11111, R, PS); step(); step();
      chk("sticky", fcs(), 32'({1'b1, 1'b1, 3'd1, 3'd3}));
      drv(R, R, R, R, PS); repeat (3) step();
      bus.clr_fault = 1'b1; step();
      bus.clr_fault = 1'b0; step();
      chk("cleared", fcs(), 32'd0);

      // Green straight to red
      do_reset();
      drv(R, G, R, R, PS); repeat (4) step();
      drv(R, R, R, R, PS); step(); step();
      chk("illegal", fcs(), 32'({1'b1, 1'b1, 3'd4, 3'd2}));

      // One-cycle yellow
      do_reset();
      drv(R, R, R, G, PS); repeat (3) step();
      drv(R, R, R, Y, PS); step();
      drv(R, R, R, R, PS); step(); step();
      chk("short_yellow", fcs(), 32'({1'b1, 1'b1, 3'd5, 3'd4}));

      // Walk with a green road, then clear and let the watchdog expire
      do_reset();
      drv(R, R, R, G, PW); step(); step();
      chk("ped_conflict", fcs(), 32'({1'b1, 1'b1, 3'd3, 3'd0}));
      drv(R, R, R, R, PS); repeat (3) step();
      bus.clr_fault = 1'b1; step();
      bus.clr_fault = 1'b0;
      repeat (60) step();
      chk("wdog_early", 32'(bus.fault), 32'd0);
      repeat (10) step();
      chk("wdog", fcs(), 32'({1'b1, 1'b1, 3'd6, 3'd0}));

      // Asynchronous reset while faulted with five rotations counted
      do_reset();
      for (int n = 0; n < 5; n++) begin
         drv(G, R, R, R, PS); repeat (2) step();
         drv(Y, R, R, R, PS); repeat (2) step();
         drv(R, R, R, R, PS); repeat (2) step();
      end
      drv(R, 5'b00000, R, R, PS); step(); step();
      chk("pre_rst_round", 32'(bus.round_cnt), 32'd5);
      chk("pre_rst_fault", fcs(), 32'({1'b1, 1'b1, 3'd1, 3'd2}));
      #2;
      reset = 1'b0;
      #1;
      chk("async_reset", dut_vec(), 32'd0);
      drv(R, R, R, R, PS);
      mdl_reset();
      @(negedge clk);
      reset = 1'b1;

      // Randomised traffic with occasional clears
      for (int n = 0; n < 400; n++) begin
         int idx;
         if ($urandom_range(0, 3) != 0) begin
            idx = $urandom_range(0, 4);
            case (idx)
               0: bus.p1 = rnd_road();
               1: bus.p2 = rnd_road();
               2: bus.p3 = rnd_road();
               3: bus.p4 = rnd_road();
               default: bus.pl = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                 : (($urandom_range(0, 1) == 0) ? PW : PS);
            endcase
         end
         bus.clr_fault = ($urandom_range(0, 7) == 0);
         step();
      end
      bus.clr_fault = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 SHALL have parameter MIN_YELLOW, default 2: minimum legal yellow dwell in clk cycles.
REQ-002 SHALL have parameter WDOG_LIMIT, default 64: cycles without any input change before a stuck fault.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 p1, p2, p3, p4  input  5 each  road lamp codes from the intersection controller.
REQ-006 pl  input  4  pedestrian lamp code.
REQ-007 clr_fault  input  1  synchronous clear of the latched fault.
REQ-008 lamp1..lamp4  output  2 each  decoded road state: 00 red, 01 green, 10 yellow, 11 invalid.
REQ-009 ped_walk  output  1  decoded pedestrian green.
REQ-010 fault  output  1  sticky fault flag.
REQ-011 fault_code  output  3  first-fault cause.
REQ-012 fault_src  output  3  first-fault source: 0 = pedestrian, 1..4 = road.
REQ-013 force_red  output  1  equals fault; requests all-red from the controller.
REQ-014 round_cnt  output  8  count of completed P1 rotations.

Function
REQ-015 Road codes SHALL decode as: GREEN = 10011, YELLOW = 01000, RED = 00100; any other value is invalid.
REQ-016 Pedestrian codes SHALL decode as: WALK = 0000, STOP = 1111; any other value is invalid.
REQ-017 All inputs SHALL be registered into a sample stage at each rising edge; the previous sample SHALL be held in a second stage.
REQ-018 lamp1..lamp4 and ped_walk SHALL reflect the sample stage, i.e. one cycle of latency from the inputs.
REQ-019 Checks SHALL compare the sample stage against the previous stage; a resulting fault SHALL be visible after the second rising edge following the offending input.
REQ-020 Each road SHALL track a state in {RED, GREEN, YELLOW}.
REQ-021 Legal road transitions SHALL be: hold, RED->GREEN, GREEN->YELLOW, YELLOW->RED; all others are illegal.
REQ-022 Each road SHALL keep a yellow dwell counter that saturates at 15 and resets on entry to YELLOW.
REQ-023 Fault codes SHALL be, with the lowest code winning when several occur in the same cycle:
- 1 = invalid code
- 2 = more than one road non-red
- 3 = ped_walk while any road is non-red
- 4 = illegal road transition
- 5 = YELLOW->RED with dwell < MIN_YELLOW
- 6 = watchdog
REQ-024 Within one code, fault_src SHALL be the lowest-numbered offender; pedestrian (0) ranks lowest.
REQ-025 The first fault SHALL latch fault, fault_code and fault_src; later faults SHALL NOT overwrite them until clr_fault.
REQ-026 clr_fault SHALL clear fault, fault_code, fault_src and the watchdog counter.
REQ-027 When clr_fault and a new fault occur in the same cycle, the new fault SHALL be latched.
REQ-028 The watchdog counter SHALL increment every cycle the sample stage equals the previous stage, and zero on any difference.
REQ-029 The watchdog counter SHALL flag code 6, src 0, when it reaches WDOG_LIMIT, then saturate.
REQ-030 round_cnt SHALL increment on each P1 RED->GREEN transition, wrapping 255->0, and SHALL keep counting while fault is set.
REQ-031 An invalid road code SHALL leave that road's tracked state unchanged.

Reset
REQ-032 While reset = 0, the following SHALL be cleared:
- lamps = 00, ped_walk = 0
- fault = 0, fault_code = 0, fault_src = 0, force_red = 0
- round_cnt = 0, watchdog and dwell counters = 0
REQ-033 While reset = 0, both sample stages SHALL load the all-red / STOP pattern, so the first post-reset P1 GREEN counts as a legal rotation.
REQ-034 Reset asserted mid-fault or mid-sequence SHALL clear all state immediately, independent of clk.

Verification
REQ-035 Normal run: controller-style sequence, 4-cycle dwells, P1->P4 then ped walk, repeated 3 times -> fault stays 0 and round_cnt = 3.
REQ-036 p1 and p2 both set to 10011 -> fault = 1, code 2, src 1, force_red = 1 two edges later.
REQ-037 p3 = 11111 -> code 1, src 3; then apply an additional conflict -> code and src unchanged; then pulse clr_fault -> fault = 0.
REQ-038 p2 GREEN->RED directly -> code 4, src 2; separately, p4 yellow for 1 cycle then RED -> code 5, src 4.
REQ-039 pl = 0000 while p4 = 10011 -> code 3, src 0; hold all inputs constant for 64 cycles after a clear -> code 6, src 0.
REQ-040 Assert reset while fault = 1 and round_cnt = 5 -> all outputs return to reset values without waiting for a clock edge.
